axi4_burst_master: RTL and testbench

// Command-driven AXI4 master that sits directly upstream of the axi4_if slave (memory DUT) and drives its AW/W/B/AR/R channels.
// A write command plus a write-data stream becomes one INCR burst on AW/W/B.
// A read command becomes one INCR burst on AR/R, with the returned data streamed out.
// One transaction is outstanding at a time. Completion is reported with the aggregated response.

---
 rtl/axi4_burst_master.sv | 197 +++++++++++++++++++
 tb/tb_axi4_burst_master.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_master.sv
// Command-driven AXI4 master: one INCR burst per command on AW/W/B or AR/R,
// one transaction outstanding, completion reported with the aggregated response.
module axi4_burst_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    // command
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    // write-data stream
    input  logic [DATA_WIDTH-1:0] wd_data,
    input  logic                  wd_valid,
    output logic                  wd_ready,
    // read-data stream
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    input  logic                  rd_ready,
    // completion
    output logic                  done_valid,
    output logic [1:0]            done_resp,
    output logic                  done_err,
    // AXI4 write address / data / response
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WVALID,
    output logic                  WLAST,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    // AXI4 read address / data
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY
);

    localparam int unsigned CNT_W = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       len_q;

    logic             w_phase;
    logic             r_phase;
    logic             at_len;
    logic [CNT_W-1:0] cnt_inc;
    logic             w_beat;
    logic             r_beat;

    assign w_phase = (state == S_W);
    assign r_phase = (state == S_R);
    assign at_len  = (cnt == CNT_W'(len_q));
    // Beat counter saturates so runaway read bursts cannot wrap back to a legal count
    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    // Data channels are combinational pass-throughs, gated off outside their phase
    assign WVALID   = w_phase & wd_valid;
    assign WDATA    = w_phase ? wd_data : '0;
    assign WLAST    = w_phase & at_len;
    assign wd_ready = w_phase & WREADY;
    assign w_beat   = WVALID & WREADY;

    assign RREADY   = r_phase & rd_ready;
    assign rd_valid = r_phase & RVALID;
    assign rd_data  = r_phase ? RDATA : '0;
    assign rd_last  = r_phase & RLAST;
    assign r_beat   = RVALID & RREADY;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            len_q      <= '0;
            cmd_ready  <= 1'b0;
            done_valid <= 1'b0;
            done_resp  <= 2'b00;
            done_err   <= 1'b0;
            AWADDR     <= '0;
            AWLEN      <= '0;
            AWSIZE     <= '0;
            AWVALID    <= 1'b0;
            BREADY     <= 1'b0;
            ARADDR     <= '0;
            ARLEN      <= '0;
            ARSIZE     <= '0;
            ARVALID    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        len_q     <= cmd_len;
                        cnt       <= '0;
                        done_resp <= 2'b00;
                        done_err  <= 1'b0;
                        if (cmd_write) begin
                            AWADDR  <= cmd_addr;
                            AWLEN   <= cmd_len;
                            AWSIZE  <= cmd_size;
                            AWVALID <= 1'b1;
                            state   <= S_AW;
                        end else begin
                            ARADDR  <= cmd_addr;
                            ARLEN   <= cmd_len;
                            ARSIZE  <= cmd_size;
                            ARVALID <= 1'b1;
                            state   <= S_AR;
                        end
                    end
                end
                S_AW: begin
                    if (AWREADY) begin
                        AWVALID <= 1'b0;
                        state   <= S_W;
                    end
                end
                S_W: begin
                    if (w_beat) begin
                        cnt <= cnt_inc;
                        if (at_len) begin
                            BREADY <= 1'b1;
                            state  <= S_B;
                        end
                    end
                end
                S_B: begin
                    if (BVALID) begin
                        BREADY     <= 1'b0;
                        done_resp  <= BRESP;
                        done_valid <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_AR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        state   <= S_R;
                    end
                end
                S_R: begin
                    if (r_beat) begin
                        cnt <= cnt_inc;
                        if (RRESP > done_resp) begin
                            done_resp <= RRESP;
                        end
                        // Early RLAST, or a beat past the requested length without RLAST
                        if ((RLAST && !at_len) || (!RLAST && (cnt >= CNT_W'(len_q)))) begin
                            done_err <= 1'b1;
                        end
                        if (RLAST) begin
                            done_valid <= 1'b1;
                            state      <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_valid <= 1'b0;
                    cmd_ready  <= 1'b1;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench for axi4_burst_master: the bench plays the AXI slave and the
// command/stream user, with expected values written out by hand per burst.
module tb_axi4_burst_master;

    logic        ACLK;
    logic        ARESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [31:0] wd_data;
    logic        wd_valid;
    logic        wd_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_last;
    logic        rd_ready;
    logic        done_valid;
    logic [1:0]  done_resp;
    logic        done_err;
    logic [15:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic        WVALID;
    logic        WLAST;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [15:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    int total = 0;
    int bad   = 0;

    axi4_burst_master dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_size   (cmd_size),
        .wd_data    (wd_data),
        .wd_valid   (wd_valid),
        .wd_ready   (wd_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_last    (rd_last),
        .rd_ready   (rd_ready),
        .done_valid (done_valid),
        .done_resp  (done_resp),
        .done_err   (done_err),
        .AWADDR     (AWADDR),
        .AWLEN      (AWLEN),
        .AWSIZE     (AWSIZE),
        .AWVALID    (AWVALID),
        .AWREADY    (AWREADY),
        .WDATA      (WDATA),
        .WVALID     (WVALID),
        .WLAST      (WLAST),
        .WREADY     (WREADY),
        .BRESP      (BRESP),
        .BVALID     (BVALID),
        .BREADY     (BREADY),
        .ARADDR     (ARADDR),
        .ARLEN      (ARLEN),
        .ARSIZE     (ARSIZE),
        .ARVALID    (ARVALID),
        .ARREADY    (ARREADY),
        .RDATA      (RDATA),
        .RRESP      (RRESP),
        .RLAST      (RLAST),
        .RVALID     (RVALID),
        .RREADY     (RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_size  = '0;
        wd_data   = '0;
        wd_valid  = 1'b0;
        rd_ready  = 1'b0;
        AWREADY   = 1'b0;
        WREADY    = 1'b0;
        BRESP     = 2'b00;
        BVALID    = 1'b0;
        ARREADY   = 1'b0;
        RDATA     = '0;
        RRESP     = 2'b00;
        RLAST     = 1'b0;
        RVALID    = 1'b0;
    endtask

    // Write burst: data 0xA0+beat, AWREADY held low aw_stall cycles, optional wd gaps
    task automatic run_write(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input int aw_stall, input bit gap, input bit lat_chk);
        int cyc;
        int beat;
        int stall;
        bit aw_done;
        bit b_done;
        bit seen;
        @(negedge ACLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_size  = size;
        #1;
        chk("wr_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge ACLK);
        cmd_valid = 1'b0;
        cyc = 1; beat = 0; stall = aw_stall; aw_done = 0; b_done = 0; seen = 0;
        while (!seen && cyc < 200) begin
            AWREADY  = !aw_done && (stall == 0);
            wd_valid = !(gap && (cyc % 2 == 0));
            wd_data  = 32'hA0 + 32'(beat);
            WREADY   = 1'b1;
            BVALID   = (beat > int'(len)) && !b_done;
            BRESP    = 2'b00;
            #1;
            if (done_valid) begin
                seen = 1;
                chk("wr_done_resp", 32'(done_resp), 32'd0);
                chk("wr_done_err", 32'(done_err), 32'd0);
                if (lat_chk) chk("wr_latency", 32'(cyc), 32'(int'(len) + 4));
            end else begin
                if (!aw_done) begin
                    chk("wr_awvalid", 32'(AWVALID), 32'd1);
                    chk("wr_awaddr", 32'(AWADDR), 32'(addr));
                    chk("wr_awlen", 32'(AWLEN), 32'(len));
                    chk("wr_awsize", 32'(AWSIZE), 32'(size));
                    chk("wr_wvalid_early", 32'(WVALID), 32'd0);
                    if (AWREADY) aw_done = 1;
                    else stall--;
                end else if (beat <= int'(len)) begin
                    chk("wr_wvalid", 32'(WVALID), 32'(wd_valid));
                    if (WVALID) begin
                        chk("wr_wdata", WDATA, 32'hA0 + 32'(beat));
                        chk("wr_wlast", 32'(WLAST), 32'(beat == int'(len)));
                        beat++;
                    end
                end else if (!b_done) begin
                    chk("wr_bready", 32'(BREADY), 32'd1);
                    b_done = 1;
                end
                @(negedge ACLK);
                cyc++;
            end
        end
        chk("wr_timeout", 32'(seen), 32'd1);
        idle_inputs();
        @(negedge ACLK);
        #1;
        chk("wr_done_pulse", 32'(done_valid), 32'd0);
        chk("wr_ready_again", 32'(cmd_ready), 32'd1);
    endtask

    // Read burst: slave returns nbeats beats data0+k, RRESP from rresps[2k+:2], RLAST on the last
    task automatic run_read(input logic [15:0] addr, input logic [7:0] len, input int nbeats,
                            input logic [31:0] data0, input logic [15:0] rresps, input bit toggle,
                            input logic [1:0] exp_resp, input logic exp_err);
        int cyc;
        int k;
        bit ar_done;
        bit seen;
        @(negedge ACLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_size  = 3'd2;
        #1;
        chk("rd_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge ACLK);
        cmd_valid = 1'b0;
        cyc = 1; k = 0; ar_done = 0; seen = 0;
        while (!seen && cyc < 200) begin
            ARREADY  = !ar_done;
            RVALID   = ar_done && (k < nbeats);
            RDATA    = data0 + 32'(k);
            RRESP    = rresps[2*k +: 2];
            RLAST    = RVALID && (k == nbeats - 1);
            rd_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            #1;
            if (done_valid) begin
                seen = 1;
                chk("rd_beats", 32'(k), 32'(nbeats));
                chk("rd_done_resp", 32'(done_resp), 32'(exp_resp));
                chk("rd_done_err", 32'(done_err), 32'(exp_err));
            end else begin
                if (!ar_done) begin
                    chk("rd_arvalid", 32'(ARVALID), 32'd1);
                    chk("rd_araddr", 32'(ARADDR), 32'(addr));
                    chk("rd_arlen", 32'(ARLEN), 32'(len));
                    ar_done = 1;
                end else if (RVALID) begin
                    chk("rd_valid", 32'(rd_valid), 32'd1);
                    chk("rd_data", rd_data, data0 + 32'(k));
                    chk("rd_last", 32'(rd_last), 32'(k == nbeats - 1));
                    chk("rd_rready", 32'(RREADY), 32'(rd_ready));
                    if (rd_ready) k++;
                end
                @(negedge ACLK);
                cyc++;
            end
        end
        chk("rd_timeout", 32'(seen), 32'd1);
        idle_inputs();
        @(negedge ACLK);
        #1;
        chk("rd_done_pulse", 32'(done_valid), 32'd0);
        chk("rd_ready_again", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        idle_inputs();
        ARESETn = 1'b0;
        repeat (3) @(negedge ACLK);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_awvalid", 32'(AWVALID), 32'd0);
        chk("rst_arvalid", 32'(ARVALID), 32'd0);
        chk("rst_done_valid", 32'(done_valid), 32'd0);
        ARESETn = 1'b1;
        @(negedge ACLK);
        #1;
        chk("rst_cmd_ready_rise", 32'(cmd_ready), 32'd1);

        // Basic zero-wait write with latency check
        run_write(16'h0010, 8'd3, 3'd2, 0, 1'b0, 1'b1);
        // Single-beat read
        run_read(16'h0040, 8'd0, 1, 32'hDEADBEEF, 16'h0000, 1'b0, 2'd0, 1'b0);
        // rd_ready toggling, SLVERR on beat 2 dominates
        run_read(16'h0080, 8'd3, 4, 32'h1234_0000, 16'h0008, 1'b1, 2'd2, 1'b0);
        // Early RLAST on beat 2
        run_read(16'h00C0, 8'd3, 2, 32'h5500_0000, 16'h0000, 1'b0, 2'd0, 1'b1);
        // RLAST late, on beat 5
        run_read(16'h0100, 8'd3, 5, 32'h6600_0000, 16'h0000, 1'b0, 2'd0, 1'b1);
        // AWREADY stalled 5 cycles, gapped write data
        run_write(16'h0200, 8'd2, 3'd1, 5, 1'b1, 1'b0);

        // Reset during the second W beat
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0300; cmd_len = 8'd3; cmd_size = 3'd2;
        @(negedge ACLK);
        cmd_valid = 1'b0; AWREADY = 1'b1;
        @(negedge ACLK);
        AWREADY = 1'b0; WREADY = 1'b1; wd_valid = 1'b1; wd_data = 32'hB0;
        @(negedge ACLK);
        wd_data = 32'hB1;
        #1;
        chk("mid_wvalid", 32'(WVALID), 32'd1);
        #1;
        ARESETn = 1'b0;
        #1;
        chk("mid_rst_wvalid", 32'(WVALID), 32'd0);
        chk("mid_rst_wd_ready", 32'(wd_ready), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_bready", 32'(BREADY), 32'd0);
        chk("mid_rst_awvalid", 32'(AWVALID), 32'd0);
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            #1;
            chk("mid_rst_no_done", 32'(done_valid), 32'd0);
        end
        ARESETn = 1'b1;
        #1;
        chk("mid_rel_cmd_ready_low", 32'(cmd_ready), 32'd0);
        @(negedge ACLK);
        #1;
        chk("mid_rel_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rel_no_done", 32'(done_valid), 32'd0);
        run_write(16'h0400, 8'd1, 3'd2, 0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
